// File: rtl/soc_addr_rules_pkg.sv
// Address-map types, the default SoC map and the range-match helper shared by
// the address decoder and anything else that needs the region rules.
package soc_addr_rules_pkg;

  typedef logic [31:0] addr_t;

  // start_addr is inclusive, end_addr is exclusive
  typedef struct packed {
    addr_t start_addr;
    addr_t end_addr;
  } addr_rule_t;

  localparam addr_rule_t ROM_ADDR_RULE = '{
    start_addr: 32'h3000_0000,
    end_addr:   32'h3000_0400
  };

  localparam addr_rule_t INST_SRAM_ADDR_RULE = '{
    start_addr: 32'h2000_0000,
    end_addr:   32'h2000_2000
  };

  localparam int SOC_N_SLV = 2;

  // index 0 = boot ROM, index 1 = instruction SRAM
  localparam addr_rule_t [SOC_N_SLV-1:0] SOC_ADDR_MAP = {INST_SRAM_ADDR_RULE, ROM_ADDR_RULE};

  function automatic logic addr_match(addr_t a, addr_rule_t r);
    return (a >= r.start_addr) && (a < r.end_addr);
  endfunction

endpackage

// File: rtl/soc_err_slave.sv
// Internal responder for unmapped accesses: grants immediately and answers
// exactly one cycle after each handshake, one response per cycle.
// SOC_ADDR_DEC_ERR_RESP_EN: when defined the response carries err_o=1,
// otherwise the access is silently absorbed (err_o=0).
module soc_err_slave (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic gnt_o,
  output logic rvalid_o,
  output logic err_o
);

`ifdef SOC_ADDR_DEC_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic pending;

  // the decoder only raises req_i when issue is allowed, so grant is unconditional
  assign gnt_o = 1'b1;

  // remember a handshake so it is answered on the following cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) pending <= 1'b0;
    else         pending <= req_i & gnt_o;
  end

  assign rvalid_o = pending;
  assign err_o    = pending & ERR_EN;

endmodule

// File: rtl/soc_addr_decoder.sv
// Single-master, N-slave OBI-style address decoder. Requests are routed by an
// N-entry address map (lowest matching index wins); unmapped addresses go to an
// internal error responder. Outstanding transactions are restricted to one
// target at a time so responses come back in order without reorder storage.
// SOC_ADDR_DEC_ERR_RESP_EN selects whether unmapped accesses report err_o=1.
module soc_addr_decoder
  import soc_addr_rules_pkg::*;
#(
  parameter int                         N_SLV           = 2,
  parameter int                         MAX_OUTSTANDING = 2,
  parameter addr_rule_t [N_SLV-1:0]     ADDR_MAP        = SOC_ADDR_MAP
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // master side
  input  logic                          req_i,
  output logic                          gnt_o,
  input  logic [31:0]                   addr_i,
  input  logic                          we_i,
  input  logic [3:0]                    be_i,
  input  logic [31:0]                   wdata_i,
  output logic                          rvalid_o,
  output logic [31:0]                   rdata_o,
  output logic                          err_o,
  // slave side
  output logic [N_SLV-1:0]              slv_req_o,
  input  logic [N_SLV-1:0]              slv_gnt_i,
  output logic [31:0]                   slv_addr_o,
  output logic                          slv_we_o,
  output logic [3:0]                    slv_be_o,
  output logic [31:0]                   slv_wdata_o,
  input  logic [N_SLV-1:0]              slv_rvalid_i,
  input  logic [N_SLV-1:0][31:0]        slv_rdata_i,
  input  logic [N_SLV-1:0]              slv_err_i
);

  localparam int TGT_W = $clog2(N_SLV + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(N_SLV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt;
  logic [TGT_W-1:0] tgt;
  logic [TGT_W-1:0] dec;
  logic             issue_ok;
  logic             hs;
  logic             err_req, err_gnt, err_rvalid, err_err;

  assign slv_addr_o  = addr_i;
  assign slv_we_o    = we_i;
  assign slv_be_o    = be_i;
  assign slv_wdata_o = wdata_i;

  // priority decode: scan downwards so the lowest matching index wins
  always_comb begin
    dec = ERR_TGT;
    for (int i = N_SLV - 1; i >= 0; i--)
      if (addr_match(addr_i, ADDR_MAP[i])) dec = TGT_W'(i);
  end

  // issue uses the registered count, so a new target waits until cnt has
  // actually drained to zero (the cycle after the last response)
  assign issue_ok = (cnt == '0) || ((cnt < CNT_MAX) && (dec == tgt));

  // route the request and its grant to/from the decoded target
  always_comb begin
    slv_req_o = '0;
    gnt_o     = 1'b0;
    err_req   = 1'b0;
    if (issue_ok) begin
      if (dec == ERR_TGT) begin
        err_req = req_i;
        gnt_o   = err_gnt;
      end
      for (int i = 0; i < N_SLV; i++) begin
        if (dec == TGT_W'(i)) begin
          slv_req_o[i] = req_i;
          gnt_o        = slv_gnt_i[i];
        end
      end
    end
  end

  // return the response of the outstanding target; anything while idle is dropped
  always_comb begin
    rvalid_o = 1'b0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (cnt != '0) begin
      if (tgt == ERR_TGT) begin
        rvalid_o = err_rvalid;
        err_o    = err_err;
      end
      for (int i = 0; i < N_SLV; i++) begin
        if (tgt == TGT_W'(i)) begin
          rvalid_o = slv_rvalid_i[i];
          rdata_o  = slv_rvalid_i[i] ? slv_rdata_i[i] : '0;
          err_o    = slv_rvalid_i[i] & slv_err_i[i];
        end
      end
    end
  end

  assign hs = req_i & gnt_o;

  // outstanding count and target; handshake plus response in one cycle nets to zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
      tgt <= '0;
    end else begin
      if (hs) tgt <= dec;
      case ({hs, rvalid_o})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  soc_err_slave u_err_slave (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (err_req),
    .gnt_o    (err_gnt),
    .rvalid_o (err_rvalid),
    .err_o    (err_err)
  );

endmodule
